// File: rtl/nash_pkg.sv
// Shared definitions for the Nash stream transmitter/receiver pair: FSM state
// encoding and the rule-30 cellular-automaton generation step.
package nash_pkg;

  // Widest CA state the shared step function accepts; callers zero-extend.
  localparam int unsigned CA_MAX_W = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    GEN   = 2'd2,
    OUT   = 2'd3
  } state_t;

  // One rule-30 generation on the low n bits of s with a cyclic boundary:
  //   nxt[i] = s[(i+1)%n] ^ (s[i] | s[(i+n-1)%n])
  // Bits of s at or above n must be zero; result bits at or above n are zero.
  function automatic logic [CA_MAX_W-1:0] ca_rule30_step(
    input logic [CA_MAX_W-1:0] s,
    input int unsigned         n
  );
    logic [CA_MAX_W-1:0] one;
    logic [CA_MAX_W-1:0] mask;
    logic [CA_MAX_W-1:0] top_bit;
    logic [CA_MAX_W-1:0] up;
    logic [CA_MAX_W-1:0] dn;
    logic                top;
    one     = {{(CA_MAX_W-1){1'b0}}, 1'b1};
    mask    = (one << n) - one;
    top_bit = one << (n - 1);
    top     = |(s & top_bit);
    // up[i] = s[i+1], with s[0] wrapping into bit n-1
    up      = (s >> 1) | ({CA_MAX_W{s[0]}} & top_bit);
    // dn[i] = s[i-1], with s[n-1] wrapping into bit 0
    dn      = (s << 1) | {{(CA_MAX_W-1){1'b0}}, top};
    return (up ^ (s | dn)) & mask;
  endfunction

endpackage

// File: rtl/nash_stream_transmitter_if.sv
// Stream bundle between plaintext source, transmitter and ciphertext channel.
interface nash_stream_transmitter_if #(
  parameter int N     = 128,
  parameter int CNT_W = 32
);
  // Handshake rule on every channel (seed, pt, ct): a transfer happens on a
  // rising clk edge where valid && ready; the producer holds valid and data
  // steady until that edge, and ready never depends on the same channel's valid.
  logic [N-1:0]     seed;
  logic             seed_valid;
  logic             seed_ready;
  logic             fb_mode;
  logic [N-1:0]     pt;
  logic             pt_valid;
  logic             pt_ready;
  logic [N-1:0]     ct;
  logic             ct_valid;
  logic             ct_ready;
  logic             zero_err;
  logic [CNT_W-1:0] words_sent;

  modport master (
    output seed, seed_valid, fb_mode, pt, pt_valid, ct_ready,
    input  seed_ready, pt_ready, ct, ct_valid, zero_err, words_sent
  );

  modport slave (
    input  seed, seed_valid, fb_mode, pt, pt_valid, ct_ready,
    output seed_ready, pt_ready, ct, ct_valid, zero_err, words_sent
  );

endinterface

// File: rtl/nash_ca_stepper.sv
// Combinational single-generation rule-30 step of an N-bit cyclic automaton.
module nash_ca_stepper
  import nash_pkg::*;
#(
  parameter int unsigned N = 128
) (
  input  logic [N-1:0] s,
  output logic [N-1:0] nxt
);

  logic [CA_MAX_W-1:0] wide_s;
  logic [CA_MAX_W-1:0] wide_nxt;
  logic                unused_hi;

  assign wide_s    = {{(CA_MAX_W-N){1'b0}}, s};
  assign wide_nxt  = ca_rule30_step(wide_s, N);
  assign nxt       = wide_nxt[N-1:0];
  // Upper bits are always zero; folded here only to keep them referenced.
  assign unused_hi = ^wide_nxt[CA_MAX_W-1:N];

endmodule

// File: rtl/nash_stream_transmitter.sv
// Streaming Nash transmitter: rule-30 keystream, STEPS generations per word,
// XORed with each plaintext word; optional ciphertext feedback reseeding.
module nash_stream_transmitter
  import nash_pkg::*;
#(
  parameter int N     = 128,
  parameter int STEPS = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nash_stream_transmitter_if.slave   bus,
  output state_t                     dbg_state
);

  localparam int CW = $clog2(STEPS + 1);

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     ca_state;
  logic [N-1:0]     ca_nxt;
  logic [N-1:0]     ct_q;
  logic [N-1:0]     pt_lat;
  logic             fb_lat;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] words_q;
  logic             zero_err_q;

  logic             seed_fire;
  logic             seed_zero;
  logic             pt_fire;
  logic             ct_fire;
  logic             last_gen;
  logic [N-1:0]     post_state;
  logic             post_zero;

  nash_ca_stepper #(.N(N)) u_stepper (
    .s   (ca_state),
    .nxt (ca_nxt)
  );

  // Readies decode from state only (pt also yields to a pending seed), so
  // ct_ready never reaches either of them combinationally.
  assign bus.seed_ready = (state == IDLE) || (state == READY);
  assign bus.pt_ready   = (state == READY) && !bus.seed_valid;
  assign bus.ct_valid   = (state == OUT);
  assign bus.ct         = ct_q;
  assign bus.zero_err   = zero_err_q;
  assign bus.words_sent = words_q;
  assign dbg_state      = state;

  assign seed_fire  = bus.seed_valid && bus.seed_ready;
  assign seed_zero  = (bus.seed == '0);
  assign pt_fire    = bus.pt_valid && bus.pt_ready;
  assign ct_fire    = bus.ct_valid && bus.ct_ready;
  assign last_gen   = (state == GEN) && (cnt == CW'(1));
  assign post_state = fb_lat ? ct_q : ca_state;
  assign post_zero  = (post_state == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (seed_fire && !seed_zero) state_nxt = READY;
      // A seed in READY reloads (or is rejected) without leaving READY.
      READY:   if (pt_fire) state_nxt = GEN;
      GEN:     if (last_gen) state_nxt = OUT;
      OUT:     if (ct_fire) state_nxt = post_zero ? IDLE : READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca_state   <= '0;
      ct_q       <= '0;
      pt_lat     <= '0;
      fb_lat     <= 1'b0;
      cnt        <= '0;
      words_q    <= '0;
      zero_err_q <= 1'b0;
    end else begin
      zero_err_q <= (seed_fire && seed_zero) || (ct_fire && post_zero);

      if (seed_fire && !seed_zero) begin
        ca_state <= bus.seed;
      end

      if (pt_fire) begin
        pt_lat <= bus.pt;
        fb_lat <= bus.fb_mode;
        cnt    <= CW'(STEPS);
      end

      if (state == GEN) begin
        ca_state <= ca_nxt;
        cnt      <= cnt - CW'(1);
        if (last_gen) begin
          ct_q <= pt_lat ^ ca_nxt;
        end
      end

      // Without feedback ca_state already holds the stepped value.
      if (ct_fire) begin
        words_q <= words_q + CNT_W'(1);
        if (fb_lat) begin
          ca_state <= ct_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_nash_stream_transmitter.sv
// Directed bench for nash_stream_transmitter (N=8): STEPS=1 instance with a
// ct scoreboard, plus a STEPS=8 instance for the asynchronous mid-GEN reset.
module tb_nash_stream_transmitter;
  import nash_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n8;
  always #5 clk = ~clk;

  nash_stream_transmitter_if #(.N(8), .CNT_W(32)) bus ();
  nash_stream_transmitter_if #(.N(8), .CNT_W(32)) bus8 ();
  state_t st;
  state_t st8;

  nash_stream_transmitter #(.N(8), .STEPS(1), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (st)
  );

  nash_stream_transmitter #(.N(8), .STEPS(8), .CNT_W(32)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n8),
    .bus       (bus8),
    .dbg_state (st8)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // Scoreboard monitor: every ct handshake on the STEPS=1 instance pops one word.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && bus.ct_valid && bus.ct_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL ct_unexpected: got %0h expected no word", bus.ct);
      end else begin
        e = exp_q.pop_front();
        check("ct_value", 32'(bus.ct), 32'(e));
      end
    end
  end

  task automatic send_seed(input logic [7:0] v);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.seed       = v;
    bus.seed_valid = 1'b1;
    @(negedge clk);
    while (!bus.seed_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.seed_ready) timeout("seed_handshake");
    @(posedge clk); #1;
    bus.seed_valid = 1'b0;
  endtask

  task automatic send_pt(input logic [7:0] v, input logic fb, input logic [7:0] exp_ct);
    int n;
    n = 0;
    exp_q.push_back(exp_ct);
    @(posedge clk); #1;
    bus.pt       = v;
    bus.fb_mode  = fb;
    bus.pt_valid = 1'b1;
    @(negedge clk);
    while (!bus.pt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pt_ready) timeout("pt_handshake");
    @(posedge clk); #1;
    bus.pt_valid = 1'b0;
  endtask

  task automatic wait_words(input logic [31:0] target);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.words_sent != target && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("words_sent", bus.words_sent, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    rst_n8 = 1'b0;
    bus.seed = '0;  bus.seed_valid = 1'b0; bus.fb_mode = 1'b0;
    bus.pt = '0;    bus.pt_valid = 1'b0;   bus.ct_ready = 1'b1;
    bus8.seed = '0; bus8.seed_valid = 1'b0; bus8.fb_mode = 1'b0;
    bus8.pt = '0;   bus8.pt_valid = 1'b0;   bus8.ct_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_seed_ready", 32'(bus.seed_ready), 1);
    check("rst_pt_ready",   32'(bus.pt_ready), 0);
    check("rst_ct_valid",   32'(bus.ct_valid), 0);
    check("rst_zero_err",   32'(bus.zero_err), 0);
    check("rst_words",      bus.words_sent, 0);
    check("rst_ct",         32'(bus.ct), 0);
    check("rst_state",      32'(st), 32'(IDLE));
    @(posedge clk); #1;
    rst_n  = 1'b1;
    rst_n8 = 1'b1;

    // 1: seed 10, pt FF -> state 38, ct C7 two cycles after pt handshake
    send_seed(8'h10);
    send_pt(8'hFF, 1'b0, 8'hC7);
    @(negedge clk);
    check("t1_gen_state", 32'(st), 32'(GEN));
    check("t1_gen_no_ct", 32'(bus.ct_valid), 0);
    @(negedge clk);
    check("t1_ct_valid",  32'(bus.ct_valid), 1);
    check("t1_ct",        32'(bus.ct), 32'h0C7);
    @(negedge clk);
    check("t1_words",     bus.words_sent, 1);
    check("t1_ready",     32'(st), 32'(READY));
    // keystream from state 38 is 64, which confirms the state kept its step
    send_pt(8'h00, 1'b0, 8'h64);
    wait_words(2);

    // 2: feedback with ct=00 -> zero_err on ct handshake, back to IDLE
    send_seed(8'h10);
    send_pt(8'h38, 1'b1, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("t2_ct_valid",  32'(bus.ct_valid), 1);
    @(negedge clk);
    check("t2_zero_err",  32'(bus.zero_err), 1);
    check("t2_idle",      32'(st), 32'(IDLE));
    check("t2_pt_ready",  32'(bus.pt_ready), 0);
    check("t2_words",     bus.words_sent, 3);
    @(negedge clk);
    check("t2_err_pulse", 32'(bus.zero_err), 0);

    // 3: zero seed in IDLE is taken but rejected
    send_seed(8'h00);
    @(negedge clk);
    check("t3_zero_err",  32'(bus.zero_err), 1);
    check("t3_idle",      32'(st), 32'(IDLE));
    check("t3_pt_ready",  32'(bus.pt_ready), 0);
    @(negedge clk);
    check("t3_err_pulse", 32'(bus.zero_err), 0);

    // 4: backpressure holds ct in OUT
    send_seed(8'h10);
    @(posedge clk); #1;
    bus.ct_ready = 1'b0;
    send_pt(8'hFF, 1'b0, 8'hC7);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("t4_ct_hold",    32'(bus.ct), 32'h0C7);
      check("t4_valid_hold", 32'(bus.ct_valid), 1);
      check("t4_seed_block", 32'(bus.seed_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.ct_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_ready",     32'(st), 32'(READY));
    check("t4_words",     bus.words_sent, 4);
    check("t4_ct_done",   32'(bus.ct_valid), 0);

    // 5: seed and pt together in READY -> seed first, pt next cycle
    exp_q.push_back(8'hC7);
    @(posedge clk); #1;
    bus.seed = 8'h10; bus.seed_valid = 1'b1;
    bus.pt = 8'hFF;   bus.pt_valid = 1'b1; bus.fb_mode = 1'b0;
    @(negedge clk);
    check("t5_pt_held",   32'(bus.pt_ready), 0);
    check("t5_seed_rdy",  32'(bus.seed_ready), 1);
    @(posedge clk); #1;
    bus.seed_valid = 1'b0;
    @(negedge clk);
    check("t5_pt_ready",  32'(bus.pt_ready), 1);
    @(posedge clk); #1;
    bus.pt_valid = 1'b0;
    wait_words(5);

    // 6: STEPS=8 instance, asynchronous reset in the middle of GEN
    @(posedge clk); #1;
    bus8.seed = 8'h10; bus8.seed_valid = 1'b1;
    @(posedge clk); #1;
    bus8.seed_valid = 1'b0;
    bus8.pt = 8'hFF;   bus8.pt_valid = 1'b1;
    @(posedge clk); #1;
    bus8.pt_valid = 1'b0;
    @(negedge clk);
    check("t6_gen",        32'(st8), 32'(GEN));
    repeat (3) @(negedge clk);
    #2;
    rst_n8 = 1'b0;
    #1;
    check("t6_rst_state",  32'(st8), 32'(IDLE));
    check("t6_rst_seedr",  32'(bus8.seed_ready), 1);
    check("t6_rst_ptr",    32'(bus8.pt_ready), 0);
    check("t6_rst_ctv",    32'(bus8.ct_valid), 0);
    check("t6_rst_ct",     32'(bus8.ct), 0);
    check("t6_rst_words",  bus8.words_sent, 0);
    @(posedge clk); #1;
    rst_n8 = 1'b1;
    bus8.pt_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_pt_reject",  32'(bus8.pt_ready), 0);
      check("t6_stay_idle",  32'(st8), 32'(IDLE));
    end
    @(posedge clk); #1;
    bus8.seed_valid = 1'b1;
    @(posedge clk); #1;
    bus8.seed_valid = 1'b0;
    @(negedge clk);
    check("t6_reseeded",   32'(st8), 32'(READY));
    check("t6_pt_ready",   32'(bus8.pt_ready), 1);
    @(posedge clk); #1;
    bus8.pt_valid = 1'b0;
    @(negedge clk);
    check("t6_gen_again",  32'(st8), 32'(GEN));
    n = 0;
    while (bus8.words_sent != 1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t6_words",      bus8.words_sent, 1);

    check("sb_drained",    32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
